// File: rtl/n_cobs_tx_scheduler.sv
// Entry queue between the N-COBS encoder and the UART: buffers variable-width
// entries, drains them byte by byte, and resyncs to the next 0x00 after a loss.
module n_cobs_tx_scheduler #(
    parameter int EntryBytes = 8,
    parameter int Depth      = 4,
    parameter int WidthW     = $clog2(EntryBytes) + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [EntryBytes*8-1:0] wr_data_i,
    input  logic [WidthW-1:0]       wr_width_i,
    input  logic                    wr_enable_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic                    overflow_o,
    input  logic                    clear_overflow_i,
    output logic                    resync_o,
    output logic                    busy_o
);
    // state | meaning
    // IDLE  | nothing loaded, tx_valid_o low
    // SEND  | head entry loaded, presenting byte idx on tx_data_o
    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [EntryBytes*8-1:0] data_mem  [Depth];
    logic [WidthW-1:0]       width_mem [Depth];
    logic [WidthW-1:0]       start_mem [Depth];

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nx;
    logic [CntW-1:0]   count_q, count_d;
    logic [WidthW-1:0] idx_q, idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              overflow_q, overflow_d;
    logic              resync_q, resync_d;

    logic [WidthW-1:0] wr_w, sent_idx, push_start, ld_start;
    logic              wr_valid, sent_found, full, push, drop, pop, ld_en;
    logic [EntryBytes*8-1:0] ld_data;

    function automatic logic [7:0] byte_sel(input logic [EntryBytes*8-1:0] d,
                                            input logic [WidthW-1:0] i);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < EntryBytes; k++)
            if (i == WidthW'(k)) b = d[k*8 +: 8];
        return b;
    endfunction

    assign wr_w      = (wr_width_i > WidthW'(EntryBytes)) ? WidthW'(EntryBytes) : wr_width_i;
    assign wr_valid  = wr_enable_i && (wr_w != '0);
    assign full      = (count_q == CntW'(Depth));
    assign rd_ptr_nx = rd_ptr_q + PtrW'(1);

    // Descending scan so the lowest-index sentinel is the one kept.
    always_comb begin
        sent_found = 1'b0;
        sent_idx   = '0;
        for (int k = EntryBytes - 1; k >= 0; k--) begin
            if ((WidthW'(k) < wr_w) && (wr_data_i[k*8 +: 8] == 8'h00)) begin
                sent_found = 1'b1;
                sent_idx   = WidthW'(k);
            end
        end
    end

    always_comb begin
        push       = 1'b0;
        drop       = 1'b0;
        push_start = '0;
        resync_d   = resync_q;
        if (wr_valid) begin
            if (!resync_q) begin
                if (full) begin
                    drop     = 1'b1;
                    resync_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end else if (sent_found && ((sent_idx + WidthW'(1)) != wr_w)) begin
                if (full) begin
                    drop = 1'b1;
                end else begin
                    push       = 1'b1;
                    push_start = sent_idx + WidthW'(1);
                    resync_d   = 1'b0;
                end
            end else if (sent_found) begin
                resync_d = 1'b0;
            end
        end
        if (drop)                  overflow_d = 1'b1;
        else if (clear_overflow_i) overflow_d = 1'b0;
        else                       overflow_d = overflow_q;
    end

    assign pop = tx_valid_q && tx_ready_i &&
                 ((idx_q + WidthW'(1)) == width_mem[rd_ptr_q]);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        ld_en      = 1'b0;
        ld_data    = wr_data_i;
        ld_start   = push_start;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    ld_en    = 1'b1;
                    ld_data  = data_mem[rd_ptr_q];
                    ld_start = start_mem[rd_ptr_q];
                end else if (push) begin
                    ld_en = 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx_ready_i) begin
                    if (pop) begin
                        // Next entry comes from the queue, or straight from the
                        // concurrent write when this was the only entry.
                        if (count_q > CntW'(1)) begin
                            ld_en    = 1'b1;
                            ld_data  = data_mem[rd_ptr_nx];
                            ld_start = start_mem[rd_ptr_nx];
                        end else if (push) begin
                            ld_en = 1'b1;
                        end else begin
                            state_d    = ST_IDLE;
                            tx_valid_d = 1'b0;
                        end
                    end else begin
                        idx_d     = idx_q + WidthW'(1);
                        tx_data_d = byte_sel(data_mem[rd_ptr_q], idx_q + WidthW'(1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (ld_en) begin
            state_d    = ST_SEND;
            idx_d      = ld_start;
            tx_data_d  = byte_sel(ld_data, ld_start);
            tx_valid_d = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (!push && pop) count_d = count_q - CntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q]  <= wr_data_i;
            width_mem[wr_ptr_q] <= wr_w;
            start_mem[wr_ptr_q] <= push_start;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
            rd_ptr_q   <= pop ? rd_ptr_nx : rd_ptr_q;
            count_q    <= count_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
            resync_q   <= resync_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign overflow_o = overflow_q;
    assign resync_o   = resync_q;
    assign busy_o     = (count_q != '0) || tx_valid_q;

endmodule
